// File: rtl/ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_sender
//
// Purpose:
//   Walks the camera register table and writes each entry to the OV7670 as a
//   3-phase SCCB write: {DEV_ADDR, x, reg, x, data, x}. The table is driven
//   through resend (rewind to entry 0) and advance (step +1). Its output word
//   arrives one clock after the address changes. An all-ones word marks the
//   end of the table.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   start    in   1-cycle pulse, run the whole table from entry 0
//   command  in   [15:0] current table word {reg, data}
//   finished in   high when command is the end-of-table marker
//   resend   out  1-cycle pulse, rewind table address to 0
//   advance  out  1-cycle pulse, step table address by one
//   busy     out  high from accepted start until the table is exhausted
//   done     out  high once the end marker has been seen
//   sioc     out  SCCB clock (push-pull)
//   siod_oe  out  1 = pull SIOD low, 0 = release
// ---------------------------------------------------------------------------
module ov7670_sccb_sender #(
    parameter int          QUARTER_CYCLES = 63,
    parameter logic [7:0]  DEV_ADDR       = 8'h42,
    parameter int          GAP_QUARTERS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        busy,
    output logic        done,
    output logic        sioc,
    output logic        siod_oe
);

    localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam int GW = (GAP_QUARTERS > 1) ? $clog2(GAP_QUARTERS) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REWIND,
        S_WAIT,
        S_CHECK,
        S_START,
        S_BITS,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [QW-1:0] r_qcnt, w_qcnt_next;
    logic [1:0]    r_phase, w_phase_next;
    logic [4:0]    r_bit, w_bit_next;
    logic [GW-1:0] r_gap, w_gap_next;
    logic          r_wait, w_wait_next;
    logic [26:0]   r_shift, w_shift_next;
    logic          r_sioc, w_sioc_next;
    logic          r_oe, w_oe_next;
    logic          r_resend, w_resend_next;
    logic          r_advance, w_advance_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic          w_qwrap;
    logic          w_timed;

    assign w_qwrap = (r_qcnt == QW'(QUARTER_CYCLES - 1));
    assign w_timed = (r_state == S_START) || (r_state == S_BITS) ||
                     (r_state == S_STOP)  || (r_state == S_GAP);

    // Next-state and datapath. Pins and status outputs are derived from the
    // state the machine is about to enter, so the registered outputs always
    // describe the current state/quarter without combinational glitches.
    always_comb begin
        w_state_next   = r_state;
        w_qcnt_next    = '0;
        w_phase_next   = r_phase;
        w_bit_next     = r_bit;
        w_gap_next     = r_gap;
        w_wait_next    = r_wait;
        w_shift_next   = r_shift;
        w_advance_next = 1'b0;

        if (w_timed) begin
            w_qcnt_next = w_qwrap ? '0 : r_qcnt + 1'b1;
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_REWIND;
                end
            end
            S_REWIND: begin
                w_wait_next  = 1'b0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // Two cycles: table address update, then registered word.
                if (r_wait) begin
                    w_state_next = S_CHECK;
                end else begin
                    w_wait_next = 1'b1;
                end
            end
            S_CHECK: begin
                if (finished) begin
                    w_state_next = S_DONE;
                end else begin
                    // ACK slots hold 1 so the bit path releases SIOD there.
                    w_shift_next = {DEV_ADDR, 1'b1, command[15:8], 1'b1,
                                    command[7:0], 1'b1};
                    w_phase_next = 2'd0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_qwrap) begin
                    if (r_phase == 2'd1) begin
                        w_phase_next = 2'd0;
                        w_bit_next   = 5'd0;
                        w_state_next = S_BITS;
                    end else begin
                        w_phase_next = r_phase + 2'd1;
                    end
                end
            end
            S_BITS: begin
                if (w_qwrap) begin
                    w_phase_next = r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        if (r_bit == 5'd26) begin
                            w_phase_next = 2'd0;
                            w_state_next = S_STOP;
                        end else begin
                            w_bit_next   = r_bit + 5'd1;
                            w_shift_next = {r_shift[25:0], 1'b0};
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_qwrap) begin
                    if (r_phase == 2'd2) begin
                        w_phase_next   = 2'd0;
                        w_gap_next     = '0;
                        w_advance_next = 1'b1;
                        w_state_next   = S_GAP;
                    end else begin
                        w_phase_next = r_phase + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (w_qwrap) begin
                    if (r_gap == GW'(GAP_QUARTERS - 1)) begin
                        w_state_next = S_CHECK;
                    end else begin
                        w_gap_next = r_gap + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Pin values for the quarter about to begin.
        w_sioc_next = 1'b1;
        w_oe_next   = 1'b0;
        case (w_state_next)
            S_START: begin
                w_sioc_next = (w_phase_next == 2'd0);
                w_oe_next   = 1'b1;
            end
            S_BITS: begin
                case (w_phase_next)
                    2'd0: begin
                        w_sioc_next = 1'b0;
                        w_oe_next   = r_oe;
                    end
                    2'd1: begin
                        // Entered from q0 of the same bit, shift reg is stable.
                        w_sioc_next = 1'b0;
                        w_oe_next   = ~r_shift[26];
                    end
                    default: begin
                        w_sioc_next = 1'b1;
                        w_oe_next   = r_oe;
                    end
                endcase
            end
            S_STOP: begin
                w_sioc_next = (w_phase_next != 2'd0);
                w_oe_next   = (w_phase_next != 2'd2);
            end
            default: begin
                w_sioc_next = 1'b1;
                w_oe_next   = 1'b0;
            end
        endcase

        w_resend_next = (w_state_next == S_REWIND);
        w_busy_next   = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
        w_done_next   = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_phase   <= 2'd0;
            r_bit     <= 5'd0;
            r_gap     <= '0;
            r_wait    <= 1'b0;
            r_shift   <= '0;
            r_sioc    <= 1'b1;
            r_oe      <= 1'b0;
            r_resend  <= 1'b0;
            r_advance <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_qcnt    <= w_qcnt_next;
            r_phase   <= w_phase_next;
            r_bit     <= w_bit_next;
            r_gap     <= w_gap_next;
            r_wait    <= w_wait_next;
            r_shift   <= w_shift_next;
            r_sioc    <= w_sioc_next;
            r_oe      <= w_oe_next;
            r_resend  <= w_resend_next;
            r_advance <= w_advance_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign resend  = r_resend;
    assign advance = r_advance;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sioc    = r_sioc;
    assign siod_oe = r_oe;

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
module tb_ov7670_sccb_sender;

    localparam int QC    = 4;
    localparam int GQ    = 4;
    localparam int FRAME = 113 * QC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] command = 16'hFFFF;
    logic        finished;
    logic        resend, advance, busy, done, sioc, siod_oe;

    always #5 clk = ~clk;

    ov7670_sccb_sender #(
        .QUARTER_CYCLES(QC),
        .DEV_ADDR      (8'h42),
        .GAP_QUARTERS  (GQ)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .command (command),
        .finished(finished),
        .resend  (resend),
        .advance (advance),
        .busy    (busy),
        .done    (done),
        .sioc    (sioc),
        .siod_oe (siod_oe)
    );

    // Register table model: address register, word registered one clock later.
    logic [15:0] tbl [0:7];
    int          addr = 0;
    always @(posedge clk) begin
        if (resend)       addr <= 0;
        else if (advance) addr <= addr + 1;
        command <= (addr < 8) ? tbl[addr] : 16'hFFFF;
    end
    assign finished = (command == 16'hFFFF);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frames and SCCB bus monitor.
    logic [15:0] exp_q [$];
    int          cyc = 0;
    int          adv_cnt = 0, res_cnt = 0, frames_done = 0, sioc_falls = 0;
    bit          in_frame = 0, have_stop = 0;
    int          nrise = 0, t_start = 0, t_stop = 0;
    logic [27:0] bits = '0;
    logic        prev_sioc = 1'b1, prev_oe = 1'b0;
    logic [15:0] last_word = '0;
    logic [7:0]  last_dev = '0;

    always @(negedge clk) begin
        logic [26:0] f;
        logic [15:0] e;
        cyc++;
        if (rst) begin
            in_frame  = 0;
            have_stop = 0;
            exp_q.delete();
            prev_sioc = 1'b1;
            prev_oe   = 1'b0;
        end else begin
            chk("pulse_overlap", {resend, advance} == 2'b11, 0);
            chk("busy_done_overlap", {busy, done} == 2'b11, 0);
            if (siod_oe != prev_oe && sioc && prev_sioc) begin
                if (siod_oe) begin
                    // START condition
                    chk("start_inside_frame", in_frame, 0);
                    if (have_stop) chk("frame_gap_ok", (cyc - t_stop) >= GQ * QC, 1);
                    in_frame = 1;
                    nrise    = 0;
                    bits     = '0;
                    t_start  = cyc;
                end else begin
                    // STOP condition
                    chk("stop_in_frame", in_frame, 1);
                    chk("stop_rises", nrise, 28);
                    chk("stop_setup_low", bits[0], 0);
                    f = bits[27:1];
                    chk("ack_slots_released", {f[18], f[9], f[0]}, 3'b111);
                    chk("frame_dev", f[26:19], 8'h42);
                    chk("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("frame_word", {f[17:10], f[8:1]}, e);
                    end
                    last_word = {f[17:10], f[8:1]};
                    last_dev  = f[26:19];
                    frames_done++;
                    in_frame  = 0;
                    have_stop = 1;
                    t_stop    = cyc;
                end
            end
            if (in_frame && sioc && !prev_sioc) begin
                bits = {bits[26:0], ~siod_oe};
                nrise++;
            end
            if (!sioc && prev_sioc) sioc_falls++;
            if (!in_frame) begin
                chk("idle_sioc_high", sioc, 1);
                chk("idle_siod_released", siod_oe, 0);
            end
            if (advance) begin
                adv_cnt++;
                chk("frame_length", cyc - t_start, FRAME);
            end
            if (resend) res_cnt++;
            prev_sioc = sioc;
            prev_oe   = siod_oe;
        end
    end

    // Run the table held in tbl[0..n-1]; optionally re-pulse start mid-run.
    task automatic run_table(input int n, input bit poke, output int lat);
        bit got;
        int k;
        for (int i = n; i < 8; i++) tbl[i] = 16'hFFFF;
        for (int i = 0; i < n; i++) exp_q.push_back(tbl[i]);
        adv_cnt   = 0;
        res_cnt   = 0;
        have_stop = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_cleared", done, 0);
        chk("busy_after_start", busy, 1);
        got = 0;
        lat = 0;
        for (k = 0; k < (n + 1) * (FRAME + GQ * QC + 20) + 20; k++) begin
            if (done) begin
                got = 1;
                break;
            end
            start = (poke && k == 60);
            tick();
        end
        start = 1'b0;
        lat = k + 1;
        chk("done_reached", got, 1);
        chk("busy_at_done", busy, 0);
        chk("advance_count", adv_cnt, n);
        chk("resend_count", res_cnt, 1);
        chk("pending_frames", exp_q.size(), 0);
        $display("run n=%0d poke=%0d cycles=%0d frames_total=%0d", n, poke, lat, frames_done);
    endtask

    initial begin
        int lat, f0, s0, n;
        logic [7:0] rr, dd;
        bit got;
        for (int i = 0; i < 8; i++) tbl[i] = 16'hFFFF;

        // Reset state
        tick(); tick(); tick();
        chk("rst_sioc", sioc, 1);
        chk("rst_oe", siod_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resend", resend, 0);
        chk("rst_advance", advance, 0);
        rst = 1'b0;
        tick();

        // start together with rst: rst wins
        tbl[0] = 16'h1280;
        res_cnt = 0;
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_wins_busy", busy, 0);
        chk("rst_wins_resend", res_cnt, 0);
        $display("rst+start same cycle: busy=%0d resend_pulses=%0d", busy, res_cnt);

        // 1: single entry
        tbl[0] = 16'h1280;
        f0 = frames_done;
        run_table(1, 0, lat);
        chk("t1_frames", frames_done - f0, 1);
        chk("t1_dev", last_dev, 8'h42);
        chk("t1_word", last_word, 16'h1280);
        chk("t1_done", done, 1);

        // 2: three entries
        tbl[0] = 16'h1204; tbl[1] = 16'h1100; tbl[2] = 16'h0C00;
        f0 = frames_done;
        run_table(3, 0, lat);
        chk("t2_frames", frames_done - f0, 3);
        chk("t2_last_word", last_word, 16'h0C00);

        // 3: empty table
        s0 = sioc_falls;
        f0 = frames_done;
        run_table(0, 0, lat);
        chk("t3_latency", lat, 5);
        chk("t3_no_sioc_toggle", sioc_falls - s0, 0);
        chk("t3_no_frames", frames_done - f0, 0);

        // 4: reset in the middle of the bit phase
        tbl[0] = 16'h1280; tbl[1] = 16'h1100; tbl[2] = 16'hFFFF;
        exp_q.push_back(16'h1280);
        adv_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 400; k++) begin
            if (in_frame && nrise >= 10) begin
                got = 1;
                break;
            end
            tick();
        end
        chk("t4_reached_bits", got, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_sioc", sioc, 1);
        chk("t4_oe", siod_oe, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        s0 = sioc_falls;
        for (int i = 0; i < 40; i++) tick();
        chk("t4_no_advance", adv_cnt, 0);
        chk("t4_quiet", sioc_falls - s0, 0);
        $display("mid-frame reset: sioc=%0d oe=%0d busy=%0d", sioc, siod_oe, busy);
        f0 = frames_done;
        run_table(2, 0, lat);
        chk("t4_rerun_frames", frames_done - f0, 2);

        // 5: start re-pulsed during a frame, then rerun after done
        tbl[0] = 16'h3A04; tbl[1] = 16'h40D0;
        f0 = frames_done;
        run_table(2, 1, lat);
        chk("t5_frames", frames_done - f0, 2);
        tbl[0] = 16'h3A04; tbl[1] = 16'h40D0;
        run_table(2, 0, lat);
        chk("t5_rerun_frames", frames_done - f0, 4);

        // Randomized tables
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin
                rr = 8'($urandom_range(0, 254));
                dd = 8'($urandom);
                tbl[i] = {rr, dd};
            end
            f0 = frames_done;
            run_table(n, 1'($urandom_range(0, 1)), lat);
            chk("rand_frames", frames_done - f0, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
